// File: rtl/imc_pkg.sv
// Shared types and constants for the IMC job scheduler.
package imc_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_BUSY,
        ST_RESPOND
    } state_t;

    localparam int IMC_OPERANDS = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         gnt_onehot_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int   idx;
        logic found;
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found             = 1'b1;
                gnt_idx_o         = IDX_W'(idx);
                gnt_onehot_o[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/imc_scheduler.sv
// Arbitrates requesters, gathers four operand words per job, drives the IMC
// and returns its result to the owning requester.
module imc_scheduler
    import imc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2,
    parameter int RES_WIDTH  = 2*DATA_WIDTH+2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_accept,
    output logic [DATA_WIDTH-1:0]         op_a,
    output logic [DATA_WIDTH-1:0]         op_b,
    output logic [DATA_WIDTH-1:0]         op_c,
    output logic [DATA_WIDTH-1:0]         op_d,
    output logic                          imc_start,
    input  logic                          imc_ready,
    input  logic                          imc_done,
    input  logic [RES_WIDTH-1:0]          imc_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [RES_WIDTH-1:0]          rsp_data,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(IMC_OPERANDS);

    state_t                 state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  word_q [IMC_OPERANDS];
    logic [DATA_WIDTH-1:0]  op_a_q, op_b_q, op_c_q, op_d_q;
    logic [RES_WIDTH-1:0]   rsp_data_q;

    logic [NUM_REQ-1:0]     arb_onehot;
    logic [IDX_W-1:0]       arb_idx;
    logic                   grant_any;
    logic [DATA_WIDTH-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_onehot_o (arb_onehot),
        .gnt_idx_o    (arb_idx)
    );

    assign grant_any = |arb_onehot;
    assign sel_data  = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    // Only the granted requester is ever accepted, and only while collecting.
    always_comb begin
        req_accept = '0;
        if (state_q == ST_COLLECT) begin
            req_accept[grant_q] = req_valid[grant_q];
        end
    end

    assign imc_start = (state_q == ST_ISSUE) && imc_ready;
    assign rsp_valid = (state_q == ST_RESPOND);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = grant_q;
    assign rsp_data  = rsp_data_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_c      = op_c_q;
    assign op_d      = op_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ-1);
            cnt_q        <= '0;
            for (int i = 0; i < IMC_OPERANDS; i++) begin
                word_q[i] <= '0;
            end
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            op_d_q       <= '0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        grant_q <= arb_idx;
                        cnt_q   <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (req_valid[grant_q]) begin
                        word_q[cnt_q] <= sel_data;
                        cnt_q         <= cnt_q + CNT_W'(1);
                        // Last word bypasses the buffer so operands are ready on ISSUE entry.
                        if (cnt_q == CNT_W'(IMC_OPERANDS-1)) begin
                            op_a_q  <= word_q[0];
                            op_b_q  <= word_q[1];
                            op_c_q  <= word_q[2];
                            op_d_q  <= sel_data;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (imc_ready) begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (imc_done) begin
                        rsp_data_q <= imc_result;
                        state_q    <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imc_scheduler.sv
// Scoreboard bench for imc_scheduler: directed jobs, queued expectations, decoupled monitor.
module tb_imc_scheduler;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam int RW = 2*DW+2;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_accept;
    logic [DW-1:0]    op_a, op_b, op_c, op_d;
    logic             imc_start;
    logic             imc_ready;
    logic             imc_done;
    logic [RW-1:0]    imc_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:0]       rsp_id;
    logic [RW-1:0]    rsp_data;
    logic             busy;

    imc_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .RES_WIDTH  (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_accept (req_accept),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_c       (op_c),
        .op_d       (op_d),
        .imc_start  (imc_start),
        .imc_ready  (imc_ready),
        .imc_done   (imc_done),
        .imc_result (imc_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    logic [DW-1:0]   src0_q[$];
    logic [DW-1:0]   src1_q[$];
    int              acc_id_q[$];
    logic [DW-1:0]   acc_data_q[$];
    logic [4*DW-1:0] op_q[$];
    int              rsp_id_q[$];
    logic [RW-1:0]   rsp_data_q[$];
    logic [RW-1:0]   res_q[$];

    int            n_chk = 0;
    int            n_pass = 0;
    int            n_acc = 0;
    int            base;
    logic [NR-1:0] gap_en;
    logic          gap_phase;
    int            imc_lat;
    int            lat_cnt;
    logic          stray_req;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_job(input int id, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                            input logic [RW-1:0] res);
        logic [DW-1:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int k = 0; k < 4; k++) begin
            if (id == 0) src0_q.push_back(w[k]);
            else         src1_q.push_back(w[k]);
            acc_id_q.push_back(id);
            acc_data_q.push_back(w[k]);
        end
        op_q.push_back({w0, w1, w2, w3});
        rsp_id_q.push_back(id);
        rsp_data_q.push_back(res);
        res_q.push_back(res);
    endtask

    task automatic clear_all();
        src0_q.delete(); src1_q.delete();
        acc_id_q.delete(); acc_data_q.delete();
        op_q.delete(); rsp_id_q.delete(); rsp_data_q.delete(); res_q.delete();
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check({name, "_busy"},       busy,       0);
        check({name, "_req_accept"}, req_accept, 0);
        check({name, "_imc_start"},  imc_start,  0);
        check({name, "_rsp_valid"},  rsp_valid,  0);
        check({name, "_rsp_id"},     rsp_id,     0);
        check({name, "_op_a"},       op_a,       0);
        check({name, "_op_d"},       op_d,       0);
        check({name, "_rsp_data"},   rsp_data,   0);
        clear_all();
        @(negedge clk);
        #5 rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!(busy == 1'b0 && src0_q.size() == 0 && src1_q.size() == 0 &&
                 acc_id_q.size() == 0 && op_q.size() == 0 && rsp_id_q.size() == 0) && k < budget) begin
            @(negedge clk); #4;
            k++;
        end
        check({name, "_done_in_time"}, k < budget, 1);
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int k = 0;
        while (n_acc < target && k < budget) begin
            @(negedge clk); #4;
            k++;
        end
        check({name, "_accepts_in_time"}, k < budget, 1);
    endtask

    task automatic wait_rsp(input int budget, input string name);
        int k = 0;
        while (!rsp_valid && k < budget) begin
            @(negedge clk); #4;
            k++;
        end
        check({name, "_rsp_in_time"}, k < budget, 1);
    endtask

    // Requester model: presents queued words, pops on accept.
    initial begin
        req_valid = '0;
        req_data  = '0;
        gap_phase = 1'b0;
        forever begin
            @(negedge clk);
            gap_phase    = ~gap_phase;
            req_valid[0] = (src0_q.size() > 0) && !(gap_en[0] && gap_phase);
            req_valid[1] = (src1_q.size() > 0) && !(gap_en[1] && gap_phase);
            req_data[DW-1:0]    = (src0_q.size() > 0) ? src0_q[0] : '0;
            req_data[2*DW-1:DW] = (src1_q.size() > 0) ? src1_q[0] : '0;
            #1;
            if (req_accept[0] && req_valid[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (req_accept[1] && req_valid[1] && src1_q.size() > 0) void'(src1_q.pop_front());
        end
    end

    // IMC model: fixed latency from start to done, plus optional stray done pulse.
    initial begin
        imc_done   = 1'b0;
        imc_result = '0;
        lat_cnt    = 0;
        forever begin
            @(negedge clk);
            imc_done = 1'b0;
            if (stray_req) begin
                imc_done   = 1'b1;
                imc_result = 34'h3BAD;
                stray_req  = 1'b0;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    imc_done   = 1'b1;
                    imc_result = (res_q.size() > 0) ? res_q.pop_front() : '0;
                end
            end
            #3;
            if (imc_start) lat_cnt = imc_lat;
        end
    end

    // Monitor: compares every DUT event against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                if (req_accept[i]) begin
                    n_acc++;
                    check("accept_has_valid", req_valid[i], 1);
                    check("accept_expected", acc_id_q.size() > 0, 1);
                    if (acc_id_q.size() > 0) begin
                        check("accept_id", i, acc_id_q.pop_front());
                        check("accept_word", req_data[i*DW +: DW], acc_data_q.pop_front());
                    end
                end
            end
            if (imc_start) begin
                check("start_expected", op_q.size() > 0, 1);
                if (op_q.size() > 0) check("operands", {op_a, op_b, op_c, op_d}, op_q.pop_front());
            end
            if (rsp_valid) begin
                check("rsp_expected", rsp_id_q.size() > 0, 1);
                if (rsp_id_q.size() > 0) begin
                    if (rsp_ready) begin
                        check("rsp_id", rsp_id, rsp_id_q.pop_front());
                        check("rsp_data", rsp_data, rsp_data_q.pop_front());
                    end else begin
                        check("rsp_id_held", rsp_id, rsp_id_q[0]);
                        check("rsp_data_held", rsp_data, rsp_data_q[0]);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        imc_ready = 1'b1;
        rsp_ready = 1'b1;
        gap_en    = '0;
        imc_lat   = 2;
        stray_req = 1'b0;
        reset_pulse("reset0");

        // Single job from requester 0
        push_job(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 34'h15);
        wait_idle(200, "single");

        // Contention from a fresh reset: 0, then 1, then 0 again
        reset_pulse("reset1");
        push_job(0, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 34'h100);
        push_job(1, 16'h0020, 16'h0021, 16'h0022, 16'h0023, 34'h200);
        push_job(0, 16'h0030, 16'h0031, 16'h0032, 16'h0033, 34'h300);
        wait_idle(400, "contention");

        // IMC not ready: start held low, operands stable
        imc_ready = 1'b0;
        base = n_acc;
        push_job(1, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 34'h777);
        wait_acc(base + 4, 200, "stall");
        repeat (5) begin
            @(negedge clk); #4;
            check("stall_start_low", imc_start, 0);
            check("stall_ops_held", {op_a, op_b, op_c, op_d}, 64'h00A1_00A2_00A3_00A4);
        end
        @(negedge clk);
        imc_ready = 1'b1;
        wait_idle(200, "stall");

        // Gapped valid on requester 1 while requester 0 waits
        gap_en[1] = 1'b1;
        base = n_acc;
        push_job(1, 16'h0041, 16'h0042, 16'h0043, 16'h0044, 34'h444);
        wait_acc(base + 1, 200, "gapped");
        push_job(0, 16'h0051, 16'h0052, 16'h0053, 16'h0054, 34'h555);
        wait_idle(400, "gapped");
        gap_en = '0;

        // Response back-pressure with a stray done pulse
        rsp_ready = 1'b0;
        push_job(1, 16'h0061, 16'h0062, 16'h0063, 16'h0064, 34'h2_0000_0666);
        wait_rsp(200, "bp");
        stray_req = 1'b1;
        repeat (3) begin
            @(negedge clk); #4;
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_data", rsp_data, 34'h2_0000_0666);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        wait_idle(200, "bp");

        // Reset after two accepts, then a clean job
        base = n_acc;
        push_job(0, 16'h0071, 16'h0072, 16'h0073, 16'h0074, 34'h1F0);
        wait_acc(base + 2, 200, "midreset");
        reset_pulse("midreset");
        push_job(1, 16'h0081, 16'h0082, 16'h0083, 16'h0084, 34'h888);
        wait_idle(200, "postreset");

        check("leftover_accepts", acc_id_q.size(), 0);
        check("leftover_starts", op_q.size(), 0);
        check("leftover_rsps", rsp_id_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
